// File: rtl/loopback_link_checker.sv
// PRBS loopback self-test: transmits a x^16+x^14+x^13+x^11+1 sequence, compares the returned stream
// against a delayed copy, and reports pass/fail. Optional tie-off checking is enabled by TIE_CHECK_EN.
module loopback_link_checker #(
    parameter int                LFSR_W   = 16,
    parameter logic [LFSR_W-1:0] SEED     = 16'hACE1,
    parameter int                LOOP_LAT = 2,
    parameter int                RUN_LEN  = 1024,
    parameter int                ERR_W    = 8
) (
`ifdef USE_POWER_PINS
    inout  wire              vdd,
    inout  wire              vss,
`endif
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             const_one,
    input  logic             const_zero,
    input  logic             rx_in,
    output logic             tx_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic             tie_fault
);

    localparam int               MAX_PH  = (LOOP_LAT > RUN_LEN) ? LOOP_LAT : RUN_LEN;
    localparam int               CNT_W   = $clog2(MAX_PH + 1);
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    typedef enum logic [1:0] {IDLE, PRIME, RUN, DONE} state_t;

    state_t              state_q, state_d;
    logic [LFSR_W-1:0]   lfsr_q, lfsr_d, lfsr_next;
    logic [CNT_W-1:0]    phase_q, phase_d;
    logic [LOOP_LAT-1:0] dly_q, dly_d;
    logic [ERR_W-1:0]    err_q, err_d;
    logic                tie_q, tie_d;
    logic                tx_q, tx_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;
    logic                expected_bit;
    logic                in_test_next;

    // Fibonacci taps at bits 0,2,3,5; the bit leaving position 0 is the transmitted bit.
    assign lfsr_next    = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[LFSR_W-1:1]};
    assign expected_bit = dly_q[LOOP_LAT-1];

`ifndef TIE_CHECK_EN
    logic unused_tie;
    assign unused_tie = const_one ^ const_zero;
`endif

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves a latch behind.
        state_d = state_q;
        lfsr_d  = lfsr_q;
        phase_d = phase_q;
        err_d   = err_q;
        tie_d   = tie_q;
        dly_d   = (dly_q << 1) | LOOP_LAT'(tx_q);

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = PRIME;
                    lfsr_d  = SEED;
                    phase_d = '0;
                    err_d   = '0;
                    tie_d   = 1'b0;
                end
            end
            PRIME: begin
                lfsr_d = lfsr_next;
                if (phase_q == CNT_W'(LOOP_LAT - 1)) begin
                    state_d = RUN;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            RUN: begin
                lfsr_d = lfsr_next;
                if ((rx_in != expected_bit) && (err_q != ERR_MAX)) begin
                    err_d = err_q + 1'b1;
                end
                if (phase_q == CNT_W'(RUN_LEN - 1)) begin
                    state_d = DONE;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef TIE_CHECK_EN
        if (((state_q == PRIME) || (state_q == RUN)) && ((const_one != 1'b1) || (const_zero != 1'b0))) begin
            tie_d = 1'b1;
        end
`endif

        // Outputs are registered from the next state so they line up with the state they describe.
        in_test_next = (state_d == PRIME) || (state_d == RUN);
        tx_d   = in_test_next & lfsr_d[0];
        busy_d = in_test_next;
        done_d = (state_d == DONE);
        pass_d = done_d & (err_d == '0) & ~tie_d;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            lfsr_q  <= '0;
            phase_q <= '0;
            dly_q   <= '0;
            err_q   <= '0;
            tie_q   <= 1'b0;
            tx_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            phase_q <= phase_d;
            dly_q   <= dly_d;
            err_q   <= err_d;
            tie_q   <= tie_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    assign tx_out    = tx_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_q;
    assign tie_fault = tie_q;

endmodule
